pwconv_weight_sched: RTL and testbench
======================================

// Module: pwconv_weight_sched
// PURPOSE
// Scheduler that sequences one PWConv layer pass: on a start pulse from the DWConv stage it walks
// every output kernel, fetches that kernel's 32-lane int8 weight word and int16 bias from the weight
// ROM, and presents them to the PWConv datapath with a one-cycle calc-enable, one kernel slot every
// ISSUE_PERIOD cycles. Sits between the dwconv valid output, the weight ROM and the PWConv array.
// PARAMETERS
// DATA_W        8   weight lane width (bits)
// LANES         32  weight lanes per ROM word
// BIAS_W        16  bias width
// KERNEL_NUM    32  output kernels per pass (ROM words 0..KERNEL_NUM-1)
// ADDR_W        6   ROM address width; must satisfy 2**ADDR_W >= KERNEL_NUM
// ISSUE_PERIOD  18  cycles per kernel slot (PWConv fine-cycle count)
// ROM_LAT       1   ROM read latency, cycles from rom_rd_o to valid data (>=1)
// PORTS
// clk           in   1                clock, rising edge
// rst_n         in   1                asynchronous active-low reset
// start_i       in   1                one-cycle pass request (dwconv valid)
// rom_rd_o      out  1                ROM read strobe
// rom_addr_o    out  ADDR_W           ROM word address = kernel index
// rom_weight_i  in   LANES*DATA_W     ROM weight word, valid ROM_LAT cycles after rom_rd_o
// rom_bias_i    in   BIAS_W           ROM bias, same timing as rom_weight_i
// weight_o      out  LANES*DATA_W     weight word held for PWConv
// bias_o        out  BIAS_W           bias held for PWConv
// calc_en_o     out  1                one-cycle PWConv calc enable, weight_o/bias_o valid
// kernel_idx_o  out  ADDR_W           kernel index of the current slot
// busy_o        out  1                pass in progress
// done_o        out  1                one-cycle pulse, pass complete
// drop_o        out  1                one-cycle pulse, start_i ignored while busy
// BEHAVIOUR
// - Reset (async, any time incl. mid-pass): state IDLE, slot counter s=0, kernel k=0; every output 0.
// - FSM: IDLE -> RUN on start_i; RUN -> DONE after slot s=ISSUE_PERIOD-1 of k=KERNEL_NUM-1;
//   DONE -> IDLE, or DONE -> RUN if start_i high in DONE (back-to-back pass, no drop).
// - Elaboration check: ISSUE_PERIOD >= ROM_LAT+2, else $error.
// - Timing, start_i high in cycle t0 while IDLE: RUN from t0+1 with k=0, s=0.
//   Per slot: s=0 -> rom_rd_o=1, rom_addr_o=k; ROM data sampled at end of cycle s=ROM_LAT into
//   weight_o/bias_o; calc_en_o=1 in cycle s=ROM_LAT+1 only. s increments each cycle; at
//   s=ISSUE_PERIOD-1 wraps to 0 and k increments.
//   First calc_en_o at t0+ROM_LAT+2; successive pulses exactly ISSUE_PERIOD apart.
// - done_o=1 for the single DONE cycle t0+1+KERNEL_NUM*ISSUE_PERIOD; busy_o=1 exactly while RUN.
// - weight_o/bias_o change only at the capture edge and hold otherwise, incl. after done and in IDLE.
// - kernel_idx_o=k during RUN, held at last value in DONE, 0 after the next start.
// - start_i while RUN: ignored, drop_o=1 next cycle, sequence unaffected.
// - start_i in IDLE or DONE: accepted, no drop_o.
// - Counters: s is $clog2(ISSUE_PERIOD) bits, k is ADDR_W bits; neither exceeds its terminal value.
// TESTING
// 1 defaults, start at t0 -> rom_addr 0..31 at t0+1+18k; calc_en at t0+3+18k (32 pulses);
//   done at t0+577; busy t0+1..t0+576.
// 2 ROM word k = {32{k}}, bias = 100+k -> at each calc_en, weight_o lanes == k and bias_o == 100+k.
// 3 start again at t0+50 -> drop_o at t0+51, calc_en/address sequence identical to test 1.
// 4 start in done cycle t0+577 -> no drop_o, rom_rd addr 0 at t0+578, second full pass.
// 5 rst_n low mid kernel 10 -> all outputs 0 at once; next start -> addr 0, calc_en start+3.
// 6 ROM_LAT=3, ISSUE_PERIOD=5, KERNEL_NUM=4 -> calc_en at t0+5,10,15,20; done at t0+21;
//   ROM data toggling outside capture cycles leaves weight_o unchanged.

Source files
------------

// File: rtl/pwconv_weight_sched.sv
// rtl/pwconv_weight_sched.sv - PWConv weight/bias scheduler.
// Walks all kernels per pass and fetches each weight word and bias from ROM into a PWConv issue slot.
module pwconv_weight_sched #(
  parameter int DATA_W       = 8,
  parameter int LANES        = 32,
  parameter int BIAS_W       = 16,
  parameter int KERNEL_NUM   = 32,
  parameter int ADDR_W       = 6,
  parameter int ISSUE_PERIOD = 18,
  parameter int ROM_LAT      = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_i,
  output logic                    rom_rd_o,
  output logic [ADDR_W-1:0]       rom_addr_o,
  input  logic [LANES*DATA_W-1:0] rom_weight_i,
  input  logic [BIAS_W-1:0]       rom_bias_i,
  output logic [LANES*DATA_W-1:0] weight_o,
  output logic [BIAS_W-1:0]       bias_o,
  output logic                    calc_en_o,
  output logic [ADDR_W-1:0]       kernel_idx_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    drop_o
);

  localparam int S_W = (ISSUE_PERIOD > 1) ? $clog2(ISSUE_PERIOD) : 1;
  localparam logic [S_W-1:0]    S_CAP  = S_W'(ROM_LAT);
  localparam logic [S_W-1:0]    S_CALC = S_W'(ROM_LAT + 1);
  localparam logic [S_W-1:0]    S_LAST = S_W'(ISSUE_PERIOD - 1);
  localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(KERNEL_NUM - 1);

  generate
    if (ISSUE_PERIOD < ROM_LAT + 2) begin : g_bad_period
      $error("pwconv_weight_sched: ISSUE_PERIOD must be >= ROM_LAT+2");
    end
    if ((2 ** ADDR_W) < KERNEL_NUM) begin : g_bad_addr
      $error("pwconv_weight_sched: ADDR_W too small for KERNEL_NUM");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [S_W-1:0]          s_q;
  logic [ADDR_W-1:0]       k_q;
  logic [LANES*DATA_W-1:0] weight_q;
  logic [BIAS_W-1:0]       bias_q;
  logic                    drop_q;
  logic                    accept;
  logic                    last_slot;

  assign accept    = start_i && (state_q != RUN);
  assign last_slot = (s_q == S_LAST) && (k_q == K_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (last_slot) state_d = DONE;
      DONE:    state_d = start_i ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // k saturates at the last kernel so kernel_idx_o holds it through DONE and IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q <= '0;
      k_q <= '0;
    end else if (accept) begin
      s_q <= '0;
      k_q <= '0;
    end else if (state_q == RUN) begin
      if (s_q == S_LAST) begin
        s_q <= '0;
        if (k_q != K_LAST) k_q <= k_q + 1'b1;
      end else begin
        s_q <= s_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      weight_q <= '0;
      bias_q   <= '0;
      drop_q   <= 1'b0;
    end else begin
      drop_q <= start_i && (state_q == RUN);
      if (state_q == RUN && s_q == S_CAP) begin
        weight_q <= rom_weight_i;
        bias_q   <= rom_bias_i;
      end
    end
  end

  assign rom_rd_o     = (state_q == RUN) && (s_q == '0);
  assign rom_addr_o   = rom_rd_o ? k_q : '0;
  assign calc_en_o    = (state_q == RUN) && (s_q == S_CALC);
  assign weight_o     = weight_q;
  assign bias_o       = bias_q;
  assign kernel_idx_o = k_q;
  assign busy_o       = (state_q == RUN);
  assign done_o       = (state_q == DONE);
  assign drop_o       = drop_q;

endmodule

// File: tb/tb_pwconv_weight_sched.sv
// tb/tb_pwconv_weight_sched.sv - self-checking bench for pwconv_weight_sched.
// Two instances: default parameters, and ROM_LAT=3 / ISSUE_PERIOD=5 / KERNEL_NUM=4.
module tb_pwconv_weight_sched;

  localparam int IP_A = 18, KN_A = 32, LAT_A = 1;
  localparam int IP_B = 5,  KN_B = 4,  LAT_B = 3;
  localparam int RD_A = 0, CALC_A = 1, DONE_A = 2, DROP_A = 3, CALC_B = 4, DONE_B = 5;

  typedef struct {
    int cyc;
    int k;
  } ev_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_a, start_b;
  logic         rom_rd_a, rom_rd_b;
  logic [5:0]   rom_addr_a, rom_addr_b;
  logic [255:0] rom_w_a, rom_w_b;
  logic [15:0]  rom_b_a, rom_b_b;
  logic [255:0] weight_a, weight_b;
  logic [15:0]  bias_a, bias_b;
  logic         calc_a, calc_b;
  logic [5:0]   kidx_a, kidx_b;
  logic         busy_a, busy_b, done_a, done_b, drop_a, drop_b;

  int  cyc = 0;
  int  n_total = 0;
  int  n_pass = 0;
  ev_t q [6][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pwconv_weight_sched dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_a),
    .rom_rd_o(rom_rd_a), .rom_addr_o(rom_addr_a),
    .rom_weight_i(rom_w_a), .rom_bias_i(rom_b_a),
    .weight_o(weight_a), .bias_o(bias_a), .calc_en_o(calc_a),
    .kernel_idx_o(kidx_a), .busy_o(busy_a), .done_o(done_a), .drop_o(drop_a)
  );

  pwconv_weight_sched #(.ROM_LAT(LAT_B), .ISSUE_PERIOD(IP_B), .KERNEL_NUM(KN_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_b),
    .rom_rd_o(rom_rd_b), .rom_addr_o(rom_addr_b),
    .rom_weight_i(rom_w_b), .rom_bias_i(rom_b_b),
    .weight_o(weight_b), .bias_o(bias_b), .calc_en_o(calc_b),
    .kernel_idx_o(kidx_b), .busy_o(busy_b), .done_o(done_b), .drop_o(drop_b)
  );

  function automatic logic [255:0] word(input int k);
    logic [255:0] w;
    for (int i = 0; i < 32; i++) w[8*i +: 8] = 8'(k);
    return w;
  endfunction

  function automatic logic [255:0] junk();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // ROM models: valid data only in the cycle ROM_LAT after the read, random junk otherwise
  logic       vb0, vb1;
  logic [5:0] ab0, ab1;
  always @(posedge clk) begin
    if (rom_rd_a) begin
      rom_w_a <= word(rom_addr_a);
      rom_b_a <= 16'(100 + rom_addr_a);
    end else begin
      rom_w_a <= junk();
      rom_b_a <= 16'($urandom);
    end
    vb0 <= rom_rd_b; ab0 <= rom_addr_b;
    vb1 <= vb0;      ab1 <= ab0;
    if (vb1) begin
      rom_w_b <= word(ab1);
      rom_b_b <= 16'(100 + ab1);
    end else begin
      rom_w_b <= junk();
      rom_b_b <= 16'($urandom);
    end
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic handle(input int id, input bit fired, input string tag,
                        output ev_t e, output bit got);
    got = 1'b0;
    e   = '{0, 0};
    if (q[id].size() > 0 && q[id][0].cyc < cyc) begin
      check({tag, " missed"}, 256'(0), 256'(1));
      void'(q[id].pop_front());
    end
    if (fired) begin
      if (q[id].size() == 0) begin
        check({tag, " unexpected"}, 256'(1), 256'(0));
      end else begin
        e   = q[id].pop_front();
        got = 1'b1;
        check({tag, " cycle"}, 256'(cyc), 256'(e.cyc));
      end
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    bit  got;
    handle(RD_A, rom_rd_a, "rd_a", e, got);
    if (got) check("rd_a addr", 256'(rom_addr_a), 256'(e.k));
    handle(CALC_A, calc_a, "calc_a", e, got);
    if (got) begin
      check("calc_a weight", weight_a, word(e.k));
      check("calc_a bias", 256'(bias_a), 256'(100 + e.k));
      check("calc_a kidx", 256'(kidx_a), 256'(e.k));
    end
    handle(DONE_A, done_a, "done_a", e, got);
    handle(DROP_A, drop_a, "drop_a", e, got);
    handle(CALC_B, calc_b, "calc_b", e, got);
    if (got) begin
      check("calc_b weight", weight_b, word(e.k));
      check("calc_b bias", 256'(bias_b), 256'(100 + e.k));
    end
    handle(DONE_B, done_b, "done_b", e, got);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic pulse_a(input bit accept);
    int t0;
    t0 = cyc;
    if (accept) begin
      for (int j = 0; j < KN_A; j++) begin
        q[RD_A].push_back('{t0 + 1 + IP_A * j, j});
        q[CALC_A].push_back('{t0 + LAT_A + 2 + IP_A * j, j});
      end
      q[DONE_A].push_back('{t0 + 1 + KN_A * IP_A, 0});
    end else begin
      q[DROP_A].push_back('{t0 + 1, 0});
    end
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic check_zero_a(input string tag);
    check({tag, " rd"},     256'(rom_rd_a),   '0);
    check({tag, " addr"},   256'(rom_addr_a), '0);
    check({tag, " weight"}, weight_a,         '0);
    check({tag, " bias"},   256'(bias_a),     '0);
    check({tag, " calc"},   256'(calc_a),     '0);
    check({tag, " kidx"},   256'(kidx_a),     '0);
    check({tag, " busy"},   256'(busy_a),     '0);
    check({tag, " done"},   256'(done_a),     '0);
    check({tag, " drop"},   256'(drop_a),     '0);
  endtask

  initial begin
    int t0, t1, t2, t3, t4;
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    repeat (3) tick();
    check_zero_a("reset");
    check("reset b weight", weight_b, '0);
    check("reset b busy", 256'(busy_b), '0);
    rst_n = 1'b1;
    repeat (2) tick();

    // full pass, a dropped start at t0+50, and a back-to-back start in the DONE cycle
    t0 = cyc;
    pulse_a(1'b1);
    check("busy at t0+1", 256'(busy_a), 256'(1));
    check("kidx at t0+1", 256'(kidx_a), 256'(0));
    wait_until(t0 + 50);
    pulse_a(1'b0);
    wait_until(t0 + 576);
    check("busy at t0+576", 256'(busy_a), 256'(1));
    wait_until(t0 + 577);
    check("busy in done", 256'(busy_a), 256'(0));
    check("done at t0+577", 256'(done_a), 256'(1));
    check("kidx in done", 256'(kidx_a), 256'(31));
    t1 = cyc;
    pulse_a(1'b1);
    check("kidx after restart", 256'(kidx_a), 256'(0));
    check("busy after restart", 256'(busy_a), 256'(1));
    wait_until(t1 + 577 + 3);
    check("idle busy", 256'(busy_a), 256'(0));
    check("idle weight hold", weight_a, word(31));
    check("idle bias hold", 256'(bias_a), 256'(131));
    check("idle kidx hold", 256'(kidx_a), 256'(31));

    // asynchronous reset in the middle of kernel 10, then a clean pass
    t2 = cyc;
    pulse_a(1'b1);
    wait_until(t2 + 1 + IP_A * 10 + 7);
    rst_n = 1'b0;
    #1;
    check_zero_a("mid reset");
    for (int i = 0; i < 6; i++) q[i].delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    t3 = cyc;
    pulse_a(1'b1);
    wait_until(t3 + 577 + 2);

    // short configuration with slow ROM
    t4 = cyc;
    for (int j = 0; j < KN_B; j++) q[CALC_B].push_back('{t4 + 5 * (j + 1), j});
    q[DONE_B].push_back('{t4 + 21, 0});
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    wait_until(t4 + 21);
    check("b done t0+21", 256'(done_b), 256'(1));
    check("b kidx in done", 256'(kidx_b), 256'(3));
    wait_until(t4 + 26);
    check("b weight hold", weight_b, word(3));
    check("b bias hold", 256'(bias_b), 256'(103));
    check("b busy idle", 256'(busy_b), 256'(0));

    tick();
    for (int i = 0; i < 6; i++) check($sformatf("queue %0d drained", i), 256'(q[i].size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
